// File: rtl/ccip_intr_ctrl.sv
// ccip_intr_ctrl: multi-vector CCI-P user-interrupt controller.
// Hardware edges and software TRIG writes set per-vector pending bits. A
// round-robin arbiter picks one eligible vector at a time and issues it as a
// single-cycle request on c1 TX, then waits for the matching response or a
// timeout before it can issue the next one.
// Optional feature macro: INTR_STATS_EN (per-vector saturating issue counters).
module ccip_intr_ctrl #(
    parameter int unsigned NUM_VEC  = 4,
    parameter logic [15:0] CSR_BASE = 16'h0020,
    parameter int unsigned ACK_TMO  = 4096,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               Clk_400,
    input  logic               SoftReset_n,
    input  logic [NUM_VEC-1:0] hw_irq,
    input  logic               mmio_wr_valid,
    input  logic               mmio_rd_valid,
    input  logic [15:0]        mmio_addr,
    input  logic [8:0]         mmio_tid,
    input  logic [63:0]        mmio_wdata,
    output logic               rd_valid,
    output logic [8:0]         rd_tid,
    output logic [63:0]        rd_data,
    input  logic               c1_almost_full,
    output logic               intr_valid,
    output logic [1:0]         intr_id,
    input  logic               intr_rsp_valid,
    input  logic [1:0]         intr_rsp_id
);

    localparam int unsigned      TMO_W    = $clog2(ACK_TMO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

    localparam logic [15:0] OFF_CTRL = 16'd0;
    localparam logic [15:0] OFF_TRIG = 16'd2;
    localparam logic [15:0] OFF_MASK = 16'd4;
    localparam logic [15:0] OFF_PEND = 16'd6;
    localparam logic [15:0] OFF_STAT = 16'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_en;
    logic [NUM_VEC-1:0]  r_mask;
    logic [NUM_VEC-1:0]  r_pend;
    logic [NUM_VEC-1:0]  r_hw_q;
    logic [1:0]          r_grant;
    logic [1:0]          r_rr_start;
    logic                r_tmo;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic [15:0]         w_off;
    logic                w_wr_ctrl;
    logic                w_wr_trig;
    logic                w_wr_mask;
    logic                w_wr_stat;
    logic [NUM_VEC-1:0]  w_elig;
    logic [NUM_VEC-1:0]  w_set;
    logic [NUM_VEC-1:0]  w_clr;
    logic [NUM_VEC-1:0]  w_arb_oh;
    logic [1:0]          w_arb_id;
    logic                w_arb_found;
    logic                w_take;
    logic                w_tmo_hit;
    logic                w_busy;
    logic [63:0]         w_rd_data;
    logic                w_unused_wdata;

    assign w_off     = mmio_addr - CSR_BASE;
    assign w_wr_ctrl = mmio_wr_valid && (w_off == OFF_CTRL);
    assign w_wr_trig = mmio_wr_valid && (w_off == OFF_TRIG);
    assign w_wr_mask = mmio_wr_valid && (w_off == OFF_MASK);
    assign w_wr_stat = mmio_wr_valid && (w_off == OFF_STAT);

    assign w_elig  = r_en ? (r_pend & ~r_mask) : '0;
    assign w_set   = (hw_irq & ~r_hw_q) | (w_wr_trig ? mmio_wdata[NUM_VEC-1:0] : '0);
    assign w_clr   = w_take ? w_arb_oh : '0;
    assign w_busy  = (r_state != ST_IDLE);
    assign intr_id = r_grant;

    // Only a few write-data bits are architecturally meaningful.
    assign w_unused_wdata = ^mmio_wdata;

    // Round-robin pick: first eligible vector at or after r_rr_start, wrapping.
    always_comb begin
        int unsigned        v;
        logic [NUM_VEC-1:0] sh;
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        w_arb_oh    = '0;
        v           = 0;
        sh          = '0;
        for (int unsigned i = 0; i < NUM_VEC; i++) begin
            v  = (32'(r_rr_start) + i) % NUM_VEC;
            sh = w_elig >> v;
            if (!w_arb_found && sh[0]) begin
                w_arb_found = 1'b1;
                w_arb_id    = 2'(v);
                w_arb_oh    = NUM_VEC'(1) << v;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    // FSM next state, grant strobe, timeout strobe and request output.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_tmo_hit   = 1'b0;
        intr_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found && !c1_almost_full) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                intr_valid  = 1'b1;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (intr_rsp_valid && (intr_rsp_id == r_grant)) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response timer: counts cycles spent in WAIT_ACK, idles at 0 elsewhere.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n)                 r_tmo_cnt <= '0;
        else if (r_state != ST_WAIT_ACK)  r_tmo_cnt <= '0;
        else                              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    // Grant latch and next round-robin start point.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_grant    <= '0;
            r_rr_start <= '0;
        end else if (w_take) begin
            r_grant    <= w_arb_id;
            r_rr_start <= 2'((32'(w_arb_id) + 1) % NUM_VEC);
        end
    end

    // Pending bits and edge history; a new event beats a same-cycle grant clear.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_pend <= '0;
            r_hw_q <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_hw_q <= hw_irq;
        end
    end

    // Software-visible control registers; timeout set beats a same-cycle W1C.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_en   <= 1'b0;
            r_mask <= '0;
            r_tmo  <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_en   <= mmio_wdata[0];
            if (w_wr_mask) r_mask <= mmio_wdata[NUM_VEC-1:0];
            if (w_tmo_hit)                         r_tmo <= 1'b1;
            else if (w_wr_stat && mmio_wdata[16])  r_tmo <= 1'b0;
        end
    end

`ifdef INTR_STATS_EN
    localparam int unsigned OFF_CNT0    = 10;
    localparam logic [15:0] OFF_CNT_CLR = 16'd18;

    logic [CNT_W-1:0]         r_cnt [NUM_VEC];
    logic [NUM_VEC*CNT_W-1:0] w_cnt_flat;
    logic                     w_wr_cnt_clr;

    assign w_wr_cnt_clr = mmio_wr_valid && (w_off == OFF_CNT_CLR);

    for (genvar g = 0; g < NUM_VEC; g++) begin : g_cnt
        // Saturating issue counter for vector g, bumped in the SEND cycle.
        always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
            if (!SoftReset_n)
                r_cnt[g] <= '0;
            else if (w_wr_cnt_clr)
                r_cnt[g] <= '0;
            else if ((r_state == ST_SEND) && (r_grant == 2'(g)) && (r_cnt[g] != '1))
                r_cnt[g] <= r_cnt[g] + CNT_W'(1);
        end
        assign w_cnt_flat[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

    // CSR read mux; reads see register values from before any same-cycle write.
    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_CTRL: w_rd_data = 64'(r_en);
            OFF_MASK: w_rd_data = 64'(r_mask);
            OFF_PEND: w_rd_data = 64'(r_pend);
            OFF_STAT: begin
                w_rd_data[1:0] = r_grant;
                w_rd_data[8]   = w_busy;
                w_rd_data[16]  = r_tmo;
            end
            default: ;
        endcase
`ifdef INTR_STATS_EN
        for (int unsigned v = 0; v < NUM_VEC; v++) begin
            if (w_off == 16'(OFF_CNT0 + 2 * v))
                w_rd_data = 64'(CNT_W'(w_cnt_flat >> (v * CNT_W)));
        end
`endif
    end

    // One-cycle read response with echoed TID.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            rd_valid <= 1'b0;
            rd_tid   <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= mmio_rd_valid;
            rd_tid   <= mmio_rd_valid ? mmio_tid : '0;
            rd_data  <= mmio_rd_valid ? w_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_ccip_intr_ctrl.sv
// Self-checking bench for ccip_intr_ctrl with a behavioural reference model.
module tb_ccip_intr_ctrl;

    localparam int unsigned NV   = 4;
    localparam logic [15:0] BASE = 16'h0020;
    localparam int unsigned TMO  = 64;

    localparam int OFF_CTRL = 0;
    localparam int OFF_TRIG = 2;
    localparam int OFF_MASK = 4;
    localparam int OFF_PEND = 6;
    localparam int OFF_STAT = 8;

    logic          clk;
    logic          rst_n;
    logic [NV-1:0] hw_irq;
    logic          mmio_wr_valid;
    logic          mmio_rd_valid;
    logic [15:0]   mmio_addr;
    logic [8:0]    mmio_tid;
    logic [63:0]   mmio_wdata;
    logic          rd_valid;
    logic [8:0]    rd_tid;
    logic [63:0]   rd_data;
    logic          c1_almost_full;
    logic          intr_valid;
    logic [1:0]    intr_id;
    logic          intr_rsp_valid;
    logic [1:0]    intr_rsp_id;

    int checks = 0;
    int errors = 0;
    int q_ids[$];

    // Reference model state
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    bit         m_en;
    bit         m_tmo;
    int         m_last;
    int         m_last_id;
    int         m_cnt[4];

    ccip_intr_ctrl #(
        .NUM_VEC (NV),
        .CSR_BASE(BASE),
        .ACK_TMO (TMO),
        .CNT_W   (32)
    ) dut (
        .Clk_400       (clk),
        .SoftReset_n   (rst_n),
        .hw_irq        (hw_irq),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .rd_valid      (rd_valid),
        .rd_tid        (rd_tid),
        .rd_data       (rd_data),
        .c1_almost_full(c1_almost_full),
        .intr_valid    (intr_valid),
        .intr_id       (intr_id),
        .intr_rsp_valid(intr_rsp_valid),
        .intr_rsp_id   (intr_rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every issued request id
    always @(negedge clk) begin
        if (rst_n && intr_valid) q_ids.push_back(int'(intr_id));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_en = 0; m_tmo = 0;
        m_last = NV - 1; m_last_id = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        q_ids.delete();
    endtask

    // Next vector the spec's round-robin rule would grant, -1 if none.
    function automatic int model_pick();
        if (!m_en) return -1;
        for (int i = 1; i <= int'(NV); i++) begin
            int v = (m_last + i) % int'(NV);
            if (m_pend[v] && !m_mask[v]) return v;
        end
        return -1;
    endfunction

    function automatic logic [63:0] model_stat(bit busy);
        return (64'(m_tmo) << 16) | (64'(busy) << 8) | 64'(m_last_id);
    endfunction

    task automatic csr_write(int off, logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_addr     = BASE + 16'(off);
        mmio_wdata    = d;
        step();
        mmio_wr_valid = 1'b0;
    endtask

    task automatic csr_read(int off, output logic [63:0] d);
        logic [8:0] tid;
        tid           = 9'($urandom);
        mmio_rd_valid = 1'b1;
        mmio_addr     = BASE + 16'(off);
        mmio_tid      = tid;
        step();
        mmio_rd_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_tid !== tid) begin
            errors++;
            $display("FAIL rd_resp off=%0d: got valid=%b tid=%0d, expected valid=1 tid=%0d",
                     off, rd_valid, rd_tid, tid);
        end
        d = rd_data;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse off=%0d: got valid=%b, expected 0", off, rd_valid);
        end
    endtask

    task automatic send_ack(int id);
        intr_rsp_valid = 1'b1;
        intr_rsp_id    = 2'(id);
        step();
        intr_rsp_valid = 1'b0;
    endtask

    task automatic expect_grant(string tag);
        int exp_id;
        int got;
        int n;
        exp_id = model_pick();
        n = 0;
        while (q_ids.size() == 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (q_ids.size() == 0) begin
            errors++;
            $display("FAIL %s: no intr_valid within 50 cycles, expected id %0d", tag, exp_id);
        end else begin
            got = q_ids.pop_front();
            if (got !== exp_id) begin
                errors++;
                $display("FAIL %s: got intr id %0d, expected %0d", tag, got, exp_id);
            end
        end
        if (exp_id >= 0) begin
            m_pend[exp_id] = 1'b0;
            m_last    = exp_id;
            m_last_id = exp_id;
            m_cnt[exp_id]++;
        end
    endtask

    task automatic expect_quiet(int n, string tag);
        repeat (n) step();
        checks++;
        if (q_ids.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d unexpected requests (first id %0d), expected none",
                     tag, q_ids.size(), q_ids[0]);
            q_ids.delete();
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        int offs[4] = '{OFF_CTRL, OFF_MASK, OFF_PEND, OFF_STAT};
        rst_n = 1'b0;
        hw_irq = '0; mmio_wr_valid = 0; mmio_rd_valid = 0; mmio_addr = '0;
        mmio_tid = '0; mmio_wdata = '0; c1_almost_full = 0;
        intr_rsp_valid = 0; intr_rsp_id = '0;
        repeat (3) step();
        checks++;
        if (intr_valid !== 0 || intr_id !== 0 || rd_valid !== 0 || rd_tid !== 0 || rd_data !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got iv=%b id=%0d rv=%b tid=%0d rd=%h, expected all 0",
                     intr_valid, intr_id, rd_valid, rd_tid, rd_data);
        end
        rst_n = 1'b1;
        model_reset();
        step();
        foreach (offs[i]) begin
            csr_read(offs[i], d);
            checks++;
            if (d !== 64'd0) begin
                errors++;
                $display("FAIL reset_csr off=%0d: got %h, expected 0", offs[i], d);
            end
        end
    endtask

    task automatic test_csr();
        logic [63:0] d;
        csr_write(OFF_CTRL, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(OFF_CTRL, d);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL ctrl_rw: got %h, expected 1", d); end
        csr_write(OFF_CTRL, 64'd0);
        csr_write(OFF_MASK, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(OFF_MASK, d);
        checks++;
        if (d !== 64'hF) begin errors++; $display("FAIL mask_width: got %h, expected f", d); end
        csr_write(OFF_MASK, 64'd0);
        csr_read(OFF_TRIG, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL trig_read: got %h, expected 0", d); end
        csr_read(1, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL unmapped_1: got %h, expected 0", d); end
        csr_read(20, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL unmapped_20: got %h, expected 0", d); end
        // Same-cycle read and write of MASK: read returns old value
        mmio_wr_valid = 1'b1; mmio_rd_valid = 1'b1;
        mmio_addr = BASE + 16'(OFF_MASK); mmio_wdata = 64'h5; mmio_tid = 9'h1A5;
        step();
        mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_tid !== 9'h1A5 || rd_data !== 64'd0) begin
            errors++;
            $display("FAIL rw_same_cycle: got v=%b tid=%h d=%h, expected v=1 tid=1a5 d=0",
                     rd_valid, rd_tid, rd_data);
        end
        step();
        csr_read(OFF_MASK, d);
        checks++;
        if (d !== 64'h5) begin errors++; $display("FAIL rw_after: got %h, expected 5", d); end
        csr_write(OFF_MASK, 64'd0);
    endtask

    task automatic test_single();
        logic [63:0] d;
        csr_write(OFF_CTRL, 64'd1);
        m_en = 1;
        mmio_wr_valid = 1'b1; mmio_addr = BASE + 16'(OFF_TRIG); mmio_wdata = 64'h1;
        m_pend[0] = 1'b1;
        step();
        mmio_wr_valid = 1'b0;
        step();
        checks++;
        if (intr_valid !== 1'b1 || intr_id !== 2'd0) begin
            errors++;
            $display("FAIL single_latency: got iv=%b id=%0d, expected iv=1 id=0", intr_valid, intr_id);
        end
        expect_grant("single_grant");
        send_ack(0);
        csr_read(OFF_STAT, d);
        checks++;
        if (d !== model_stat(0)) begin
            errors++;
            $display("FAIL single_stat: got %h, expected %h", d, model_stat(0));
        end
        csr_read(OFF_PEND, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL single_pend: got %h, expected 0", d); end
    endtask

    task automatic test_round_robin();
        csr_write(OFF_TRIG, 64'hF);
        m_pend |= 4'hF;
        for (int i = 0; i < 4; i++) begin
            expect_grant("rr_all");
            send_ack(m_last_id);
        end
        expect_quiet(4, "rr_all_done");
        csr_write(OFF_TRIG, 64'h3);
        m_pend |= 4'h3;
        for (int i = 0; i < 2; i++) begin
            expect_grant("rr_wrap");
            send_ack(m_last_id);
        end
        expect_quiet(4, "rr_wrap_done");
    endtask

    task automatic test_back_to_back();
        int nxt;
        csr_write(OFF_TRIG, 64'hC);
        m_pend |= 4'hC;
        expect_grant("b2b_first");
        send_ack(m_last_id);
        nxt = model_pick();
        checks++;
        if (intr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got intr_valid=%b one cycle after ack, expected 0", intr_valid);
        end
        step();
        checks++;
        if (intr_valid !== 1'b1 || int'(intr_id) !== nxt) begin
            errors++;
            $display("FAIL b2b_next: got iv=%b id=%0d, expected iv=1 id=%0d", intr_valid, intr_id, nxt);
        end
        expect_grant("b2b_second");
        send_ack(m_last_id);
    endtask

    task automatic test_mask_hw();
        logic [63:0] d;
        csr_write(OFF_MASK, 64'h2);
        m_mask = 4'h2;
        hw_irq[1] = 1'b1;
        m_pend[1] = 1'b1;
        expect_quiet(8, "mask_hold");
        csr_read(OFF_PEND, d);
        checks++;
        if (d !== 64'(m_pend)) begin
            errors++;
            $display("FAIL mask_pend: got %h, expected %h", d, m_pend);
        end
        csr_write(OFF_MASK, 64'd0);
        m_mask = 4'h0;
        expect_grant("unmask_grant");
        send_ack(m_last_id);
        expect_quiet(6, "hw_level_no_retrigger");
        hw_irq[1] = 1'b0;
        step();
    endtask

    task automatic test_almost_full();
        logic [63:0] d;
        c1_almost_full = 1'b1;
        csr_write(OFF_TRIG, 64'h8);
        m_pend[3] = 1'b1;
        expect_quiet(10, "af_hold");
        csr_read(OFF_PEND, d);
        checks++;
        if (d !== 64'(m_pend)) begin
            errors++;
            $display("FAIL af_pend: got %h, expected %h", d, m_pend);
        end
        c1_almost_full = 1'b0;
        expect_grant("af_release");
        send_ack(m_last_id);
    endtask

    task automatic test_timeout();
        logic [63:0] d;
        csr_write(OFF_TRIG, 64'h4);
        m_pend[2] = 1'b1;
        expect_grant("tmo_issue");
        repeat (TMO - 5) step();
        csr_read(OFF_STAT, d);
        checks++;
        if (d !== model_stat(1)) begin
            errors++;
            $display("FAIL tmo_before: got %h, expected %h", d, model_stat(1));
        end
        repeat (10) step();
        m_tmo = 1;
        csr_read(OFF_STAT, d);
        checks++;
        if (d !== model_stat(0)) begin
            errors++;
            $display("FAIL tmo_after: got %h, expected %h", d, model_stat(0));
        end
        csr_read(OFF_PEND, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL tmo_not_repended: got %h, expected 0", d); end
        expect_quiet(5, "tmo_quiet");
        csr_write(OFF_STAT, 64'h1_0000);
        m_tmo = 0;
        csr_read(OFF_STAT, d);
        checks++;
        if (d !== model_stat(0)) begin
            errors++;
            $display("FAIL tmo_w1c: got %h, expected %h", d, model_stat(0));
        end
`ifdef INTR_STATS_EN
        csr_read(10 + 2 * 2, d);
        checks++;
        if (d !== 64'(m_cnt[2])) begin
            errors++;
            $display("FAIL stats_cnt2: got %0d, expected %0d", d, m_cnt[2]);
        end
        csr_write(18, 64'd0);
        for (int v = 0; v < 4; v++) m_cnt[v] = 0;
        csr_read(10, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL stats_clear: got %0d, expected 0", d); end
`else
        for (int off = 10; off <= 18; off += 2) begin
            csr_read(off, d);
            checks++;
            if (d !== 64'd0) begin
                errors++;
                $display("FAIL stats_absent off=%0d: got %h, expected 0", off, d);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [3:0]  msk;
        logic [3:0]  trg;
        int          wrong;
        for (int it = 0; it < 8; it++) begin
            msk = 4'($urandom);
            trg = 4'($urandom);
            csr_write(OFF_MASK, 64'(msk));
            m_mask = msk;
            csr_write(OFF_TRIG, 64'(trg));
            m_pend |= trg;
            for (int pass = 0; pass < 2; pass++) begin
                while (model_pick() >= 0) begin
                    expect_grant("rand_grant");
                    if ($urandom_range(0, 1) == 1) begin
                        wrong = (m_last_id + 1 + int'($urandom_range(0, 2))) % 4;
                        send_ack(wrong);
                        csr_read(OFF_STAT, d);
                        checks++;
                        if (d !== model_stat(1)) begin
                            errors++;
                            $display("FAIL rand_wrong_ack id=%0d: got stat %h, expected %h",
                                     wrong, d, model_stat(1));
                        end
                    end
                    repeat ($urandom_range(0, 3)) step();
                    send_ack(m_last_id);
                end
                expect_quiet(6, "rand_drained");
                csr_read(OFF_PEND, d);
                checks++;
                if (d !== 64'(m_pend)) begin
                    errors++;
                    $display("FAIL rand_pend it=%0d pass=%0d: got %h, expected %h", it, pass, d, m_pend);
                end
                csr_write(OFF_MASK, 64'd0);
                m_mask = '0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        csr_write(OFF_MASK, 64'h2);
        m_mask = 4'h2;
        csr_write(OFF_TRIG, 64'hF);
        step();
        checks++;
        if (intr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_send: got intr_valid=%b, expected 1", intr_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (intr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got intr_valid=%b during reset, expected 0", intr_valid);
        end
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        step();
        csr_read(OFF_PEND, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL rstmid_pend: got %h, expected 0", d); end
        csr_read(OFF_STAT, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL rstmid_stat: got %h, expected 0", d); end
        expect_quiet(4, "rstmid_quiet");
        csr_write(OFF_CTRL, 64'd1);
        m_en = 1;
        csr_write(OFF_TRIG, 64'hF);
        m_pend = 4'hF;
        for (int i = 0; i < 4; i++) begin
            expect_grant("rstmid_order");
            send_ack(m_last_id);
        end
        expect_quiet(4, "rstmid_done");
    endtask

    initial begin
        test_reset();
        test_csr();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_mask_hw();
        test_almost_full();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
